// File: rtl/ntlm_pkg.sv
// ntlm_pkg: shared types and widths for the NTLM crack sequencer.
//   state_t : controller states
//   HASH_W  : digest width
//   BUF_W   : candidate buffer width
//   LEN_W   : candidate length width
//   BYTE_W  : bits per packed candidate character
package ntlm_pkg;

  localparam int HASH_W = 128;
  localparam int BUF_W  = 128;
  localparam int LEN_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    FOUND,
    EXHAUSTED
  } state_t;

endpackage

// File: rtl/ntlm_cand_counter.sv
// ntlm_cand_counter: mixed-radix candidate enumerator.
// It holds one base-CHARSET_SIZE digit per character and the current length.
// It packs the active digits into ASCII bytes, with char0 at instr[0:7].
//   clk, rst : clock and synchronous active-high reset
//   load     : start a fresh search (len = MIN_LEN, digits = 0)
//   incr     : step to the next candidate of the same length
//   grow     : move to the first candidate of length len+1
//   len      : current candidate length
//   instr    : packed candidate bytes; unused bytes are zero
//   wrap     : carry out of the top active digit if incr were applied
module ntlm_cand_counter
  import ntlm_pkg::*;
#(
  parameter logic [7:0] BASE_CHAR    = 8'h61,
  parameter int         CHARSET_SIZE = 26,
  parameter int         MIN_LEN      = 1,
  parameter int         MAX_LEN_HW   = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             incr,
  input  logic             grow,
  output logic [LEN_W-1:0] len,
  output logic [0:BUF_W-1] instr,
  output logic             wrap
);

  localparam int               DIG_W   = $clog2(CHARSET_SIZE);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(CHARSET_SIZE - 1);

  logic [DIG_W-1:0] dig_q [MAX_LEN_HW];
  logic [DIG_W-1:0] dig_d [MAX_LEN_HW];
  logic [LEN_W-1:0] len_q;

  // Ripple increment: d[0] is the least significant digit.
  // Only digits below len_q take part in the increment.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < MAX_LEN_HW; i++) begin
      dig_d[i] = dig_q[i];
      if ((i < int'(len_q)) && carry) begin
        if (dig_q[i] == DIG_MAX) begin
          dig_d[i] = '0;
        end else begin
          dig_d[i] = dig_q[i] + DIG_W'(1);
          carry    = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_comb begin
    instr = '0;
    for (int i = 0; i < MAX_LEN_HW; i++) begin
      if (i < int'(len_q)) begin
        instr[i*BYTE_W +: BYTE_W] = BASE_CHAR + BYTE_W'(dig_q[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      for (int i = 0; i < MAX_LEN_HW; i++) dig_q[i] <= '0;
    end else if (load || grow) begin
      len_q <= load ? LEN_W'(MIN_LEN) : len_q + LEN_W'(1);
      for (int i = 0; i < MAX_LEN_HW; i++) dig_q[i] <= '0;
    end else if (incr) begin
      for (int i = 0; i < MAX_LEN_HW; i++) dig_q[i] <= dig_d[i];
    end
  end

  assign len = len_q;

endmodule

// File: rtl/ntlm_crack_ctrl.sv
// ntlm_crack_ctrl: brute-force sequencer in front of a single NTLM hash core.
// It enumerates candidates shortest first and issues each one through start/done.
// It compares each returned digest with the latched target.
// It stops on the first match or when every length up to the limit is exhausted.
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : host control (start pulse, abort level)
//   target_hash,max_len : search parameters, sampled on an accepted start
//   core_*              : hash core handshake and candidate buffer
//   busy, done, found   : status
//   found_instr/length  : matching candidate, valid while found
//   try_count           : completed candidates
// Optional build macro NTLM_CTRL_TRY_COUNT_EN enables try_count, a saturating
// 32-bit counter. Without the macro, try_count is tied to zero.
module ntlm_crack_ctrl
  import ntlm_pkg::*;
#(
  parameter logic [7:0] BASE_CHAR    = 8'h61,
  parameter int         CHARSET_SIZE = 26,
  parameter int         MIN_LEN      = 1,
  parameter int         MAX_LEN_HW   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [0:HASH_W-1] target_hash,
  input  logic [0:LEN_W-1]  max_len,
  output logic [0:BUF_W-1]  core_instr,
  output logic [0:LEN_W-1]  core_length,
  output logic              core_start,
  input  logic              core_done,
  input  logic [0:HASH_W-1] core_hash,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [0:BUF_W-1]  found_instr,
  output logic [0:LEN_W-1]  found_length,
  output logic [0:31]       try_count
);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req);
    logic [LEN_W-1:0] res;
    res = req;
    if (int'(req) < MIN_LEN)         res = LEN_W'(MIN_LEN);
    else if (int'(req) > MAX_LEN_HW) res = LEN_W'(MAX_LEN_HW);
    return res;
  endfunction

  state_t state_q, state_d;
  logic [LEN_W-1:0]  lim_q;
  logic [HASH_W-1:0] target_q, hash_q;
  logic              take_start, take_hash, take_found;
  logic              cnt_load, cnt_incr, cnt_grow, cnt_wrap;
  logic [LEN_W-1:0]  cnt_len;
  logic [0:BUF_W-1]  cnt_instr;

  ntlm_cand_counter #(
    .BASE_CHAR    (BASE_CHAR),
    .CHARSET_SIZE (CHARSET_SIZE),
    .MIN_LEN      (MIN_LEN),
    .MAX_LEN_HW   (MAX_LEN_HW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .incr  (cnt_incr),
    .grow  (cnt_grow),
    .len   (cnt_len),
    .instr (cnt_instr),
    .wrap  (cnt_wrap)
  );

  // Abort overrides everything, including a start in the same cycle.
  always_comb begin
    state_d    = state_q;
    take_start = 1'b0;
    take_hash  = 1'b0;
    take_found = 1'b0;
    cnt_load   = 1'b0;
    cnt_incr   = 1'b0;
    cnt_grow   = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, FOUND, EXHAUSTED: begin
          if (start) begin
            take_start = 1'b1;
            cnt_load   = 1'b1;
            state_d    = ISSUE;
          end
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (core_done) begin
            take_hash = 1'b1;
            state_d   = CHECK;
          end
        end
        CHECK: begin
          if (hash_q == target_q) begin
            take_found = 1'b1;
            state_d    = FOUND;
          end else if (!cnt_wrap) begin
            cnt_incr = 1'b1;
            state_d  = ISSUE;
          end else if (cnt_len == lim_q) begin
            state_d = EXHAUSTED;
          end else begin
            cnt_grow = 1'b1;
            state_d  = ISSUE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lim_q        <= '0;
      found_instr  <= '0;
      found_length <= '0;
    end else begin
      state_q <= state_d;
      if (take_start) lim_q <= clamp_len(max_len);
      if (take_found) begin
        found_instr  <= cnt_instr;
        found_length <= cnt_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take_start) target_q <= target_hash;
    if (take_hash)  hash_q   <= core_hash;
  end

  assign core_instr  = cnt_instr;
  assign core_length = cnt_len;
  assign core_start  = (state_q == ISSUE);
  assign busy        = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CHECK);
  assign done        = (state_q == FOUND) || (state_q == EXHAUSTED);
  assign found       = (state_q == FOUND);

`ifdef NTLM_CTRL_TRY_COUNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] tries_q;

  always_ff @(posedge clk) begin
    if (rst)                    tries_q <= '0;
    else if (take_start)        tries_q <= '0;
    else if (state_q == CHECK)  tries_q <= sat_inc(tries_q);
  end

  assign try_count = tries_q;
`else
  assign try_count = '0;
`endif

endmodule

// File: tb/tb_ntlm_crack_ctrl.sv
module tb_ntlm_crack_ctrl;

  localparam logic [0:127] PAD = {16{8'hA5}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [0:127] target_hash = '0;
  logic [0:3]   max_len = '0;
  logic [0:127] core_instr, found_instr;
  logic [0:3]   core_length, found_length;
  logic         core_start, busy, done, found;
  logic         core_done = 1'b0;
  logic [0:127] core_hash = '0;
  logic [0:31]  try_count;

  logic         b_start = 1'b0, b_abort = 1'b0;
  logic [0:127] b_target = '0;
  logic [0:3]   b_max_len = '0;
  logic [0:127] b_core_instr, b_found_instr;
  logic [0:3]   b_core_length, b_found_length;
  logic         b_core_start, b_busy, b_done, b_found;
  logic         b_core_done = 1'b0;
  logic [0:127] b_core_hash = '0;
  logic [0:31]  b_try_count;

  ntlm_crack_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .target_hash(target_hash),
    .max_len(max_len), .core_instr(core_instr), .core_length(core_length),
    .core_start(core_start), .core_done(core_done), .core_hash(core_hash),
    .busy(busy), .done(done), .found(found), .found_instr(found_instr),
    .found_length(found_length), .try_count(try_count)
  );

  // Binary charset starting at length 13 makes a length-14 candidate reachable.
  ntlm_crack_ctrl #(.CHARSET_SIZE(2), .MIN_LEN(13)) u_dut14 (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .target_hash(b_target),
    .max_len(b_max_len), .core_instr(b_core_instr), .core_length(b_core_length),
    .core_start(b_core_start), .core_done(b_core_done), .core_hash(b_core_hash),
    .busy(b_busy), .done(b_done), .found(b_found), .found_instr(b_found_instr),
    .found_length(b_found_length), .try_count(b_try_count)
  );

  // Core model: hash = instr ^ A5..A5 after lat cycles (lat == 0 picks 1..5 at random).
  int           lat = 0;
  int           m_cnt = 0;
  logic [0:127] m_instr = '0;
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        core_done <= 1'b1;
        core_hash <= m_instr ^ PAD;
      end
    end
    if (core_start) begin
      m_instr <= core_instr;
      m_cnt   <= (lat == 0) ? int'($urandom_range(1, 5)) : lat;
    end
  end

  always @(posedge clk) begin
    b_core_done <= b_core_start;
    b_core_hash <= b_core_instr ^ PAD;
  end

  int           issue_total = 0, b_issue_total = 0, done_total = 0, dbl_start = 0;
  logic         prev_cs = 1'b0;
  logic [0:127] last_instr = '0;
  always @(posedge clk) begin
    if (core_start) begin
      issue_total <= issue_total + 1;
      last_instr  <= core_instr;
    end
    if (b_core_start) b_issue_total <= b_issue_total + 1;
    if (core_done) done_total <= done_total + 1;
    if (core_start && prev_cs) dbl_start <= dbl_start + 1;
    prev_cs <= core_start;
  end

  int n_vec = 0, n_bad = 0;

  function automatic longint ipow(int b, int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Candidate with numeric value val in base cs, least-significant char first.
  function automatic logic [0:127] make_instr(int cs, int len, longint val);
    logic [0:127] r;
    longint v;
    r = '0;
    v = val;
    for (int i = 0; i < len; i++) begin
      r[i*8 +: 8] = 8'(64'h61 + (v % cs));
      v = v / cs;
    end
    return r;
  endfunction

  function automatic longint tries_to_find(int cs, int minl, int len, longint val);
    longint s = 0;
    for (int k = minl; k < len; k++) s = s + ipow(cs, k);
    return s + val + 1;
  endfunction

  function automatic longint tries_to_exhaust(int cs, int minl, int lim);
    longint s = 0;
    for (int k = minl; k <= lim; k++) s = s + ipow(cs, k);
    return s;
  endfunction

  function automatic int clamp_ref(int ml);
    return (ml < 1) ? 1 : (ml > 14) ? 14 : ml;
  endfunction

  function automatic longint tc_ref(longint t);
`ifdef NTLM_CTRL_TRY_COUNT_EN
    return t;
`else
    return 0 * t;
`endif
  endfunction

  task automatic run_search(input logic [0:127] tgt, input int ml, input int budget,
                            output int tries, output bit timeout);
    int s;
    @(negedge clk);
    target_hash = tgt;
    max_len     = 4'(ml);
    start       = 1'b1;
    s           = issue_total;
    @(negedge clk);
    start   = 1'b0;
    timeout = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    tries = issue_total - s;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (core_instr !== '0) begin n_bad++; $display("FAIL reset_core_instr: got %h want 0", core_instr); end
    n_vec++; if ({core_length, core_start, busy, done, found} !== '0) begin n_bad++; $display("FAIL reset_status: got %b want 0", {core_length, core_start, busy, done, found}); end
    n_vec++; if ({found_instr, found_length, try_count} !== '0) begin n_bad++; $display("FAIL reset_found: got %h want 0", {found_instr, found_length, try_count}); end
  endtask

  task automatic test_find_c();
    int t; bit to;
    lat = 0;
    run_search(make_instr(26, 1, 2) ^ PAD, 2, 3000, t, to);
    n_vec++; if (to) begin n_bad++; $display("FAIL c_timeout: got timeout want done"); end
    n_vec++; if ({busy, done, found} !== 3'b011) begin n_bad++; $display("FAIL c_status: got %b want 011", {busy, done, found}); end
    n_vec++; if (found_instr[0:7] !== 8'h63) begin n_bad++; $display("FAIL c_char: got %h want 63", found_instr[0:7]); end
    n_vec++; if (found_instr !== make_instr(26, 1, 2)) begin n_bad++; $display("FAIL c_instr: got %h want %h", found_instr, make_instr(26, 1, 2)); end
    n_vec++; if (found_length !== 4'd1) begin n_bad++; $display("FAIL c_len: got %0d want 1", found_length); end
    n_vec++; if (t != 3) begin n_bad++; $display("FAIL c_tries: got %0d want 3", t); end
    n_vec++; if (try_count !== tc_ref(3)) begin n_bad++; $display("FAIL c_try_count: got %0d want %0d", try_count, tc_ref(3)); end
  endtask

  // Start pulses during the search (with a different target) must not restart it.
  task automatic test_find_ab_start_busy();
    int s, t; bit to;
    lat = 0;
    @(negedge clk);
    target_hash = make_instr(26, 2, 26) ^ PAD;
    max_len = 4'd3; start = 1'b1; s = issue_total;
    @(negedge clk);
    start = 1'b0; to = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin start = 1'b0; to = 1'b0; break; end
      if (c % 7 == 3) begin start = 1'b1; target_hash = make_instr(26, 1, 0) ^ PAD; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    t = issue_total - s;
    n_vec++; if (to) begin n_bad++; $display("FAIL ab_timeout: got timeout want done"); end
    n_vec++; if (found_instr[0:15] !== 16'h6162) begin n_bad++; $display("FAIL ab_chars: got %h want 6162", found_instr[0:15]); end
    n_vec++; if (found_length !== 4'd2 || found !== 1'b1) begin n_bad++; $display("FAIL ab_len: got %0d/%b want 2/1", found_length, found); end
    n_vec++; if (t != 53) begin n_bad++; $display("FAIL ab_tries: got %0d want 53", t); end
    n_vec++; if (try_count !== tc_ref(53)) begin n_bad++; $display("FAIL ab_try_count: got %0d want %0d", try_count, tc_ref(53)); end
  endtask

  task automatic test_exhaust();
    int t; bit to;
    lat = 0;
    run_search('0, 2, 7000, t, to);
    n_vec++; if (to) begin n_bad++; $display("FAIL ex_timeout: got timeout want done"); end
    n_vec++; if ({done, found} !== 2'b10) begin n_bad++; $display("FAIL ex_status: got %b want 10", {done, found}); end
    n_vec++; if (t != 702) begin n_bad++; $display("FAIL ex_tries: got %0d want 702", t); end
    n_vec++; if (last_instr !== make_instr(26, 2, 675)) begin n_bad++; $display("FAIL ex_last: got %h want %h", last_instr, make_instr(26, 2, 675)); end
    n_vec++; if (try_count !== tc_ref(702)) begin n_bad++; $display("FAIL ex_try_count: got %0d want %0d", try_count, tc_ref(702)); end
  endtask

  task automatic test_random();
    int t, tl, ml, lim; longint tv, exp_t; bit to, exp_f;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      tl  = int'($urandom_range(1, 2));
      tv  = longint'($urandom_range(0, 32'(ipow(26, tl) - 1)));
      ml  = int'($urandom_range(0, 15));
      lim = clamp_ref(ml);
      exp_f = (tl <= lim);
      exp_t = exp_f ? tries_to_find(26, 1, tl, tv) : tries_to_exhaust(26, 1, lim);
      run_search(make_instr(26, tl, tv) ^ PAD, ml, 7000, t, to);
      n_vec++; if (to) begin n_bad++; $display("FAIL rnd_timeout: got timeout want done"); end
      n_vec++; if (found !== exp_f) begin n_bad++; $display("FAIL rnd_found: got %b want %b (len %0d val %0d max %0d)", found, exp_f, tl, tv, ml); end
      n_vec++; if (t != exp_t) begin n_bad++; $display("FAIL rnd_tries: got %0d want %0d", t, exp_t); end
      if (exp_f) begin
        n_vec++; if (found_instr !== make_instr(26, tl, tv) || found_length !== 4'(tl)) begin n_bad++; $display("FAIL rnd_match: got %h/%0d want %h/%0d", found_instr, found_length, make_instr(26, tl, tv), tl); end
      end
    end
  endtask

  task automatic test_abort();
    int s, d0, t; bit to;
    lat = 5;
    @(negedge clk);
    target_hash = '0; max_len = 4'd2; start = 1'b1; s = issue_total;
    @(negedge clk);
    start = 1'b0; to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (issue_total - s >= 10) begin to = 1'b0; break; end
      @(negedge clk);
    end
    n_vec++; if (to) begin n_bad++; $display("FAIL ab10_timeout: got %0d issues want 10", issue_total - s); end
    abort = 1'b1;
    d0 = done_total;
    @(negedge clk);
    abort = 1'b0;
    n_vec++; if ({busy, done, found} !== 3'b000) begin n_bad++; $display("FAIL abort_idle: got %b want 000", {busy, done, found}); end
    repeat (8) @(negedge clk);
    n_vec++; if (done_total - d0 != 1 || busy !== 1'b0 || issue_total - s != 10) begin n_bad++; $display("FAIL abort_stale: got done %0d busy %b issues %0d want 1/0/10", done_total - d0, busy, issue_total - s); end
    lat = 0;
    target_hash = make_instr(26, 1, 0) ^ PAD; max_len = 4'd2; start = 1'b1; s = issue_total;
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (core_start !== 1'b1 || core_instr !== make_instr(26, 1, 0) || core_length !== 4'd1) begin n_bad++; $display("FAIL restart_first: got %b %h %0d want 1 %h 1", core_start, core_instr, core_length, make_instr(26, 1, 0)); end
    n_vec++; if (try_count !== '0) begin n_bad++; $display("FAIL restart_try_count: got %0d want 0", try_count); end
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    t = issue_total - s;
    n_vec++; if (to || found !== 1'b1 || t != 1) begin n_bad++; $display("FAIL restart_find: got found %b tries %0d want 1/1", found, t); end
  endtask

  task automatic test_rst_check();
    int s; bit to;
    lat = 0;
    @(negedge clk);
    target_hash = '0; max_len = 4'd2; start = 1'b1; s = issue_total;
    @(negedge clk);
    start = 1'b0; to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (core_done && (issue_total - s >= 3)) begin to = 1'b0; break; end
      @(negedge clk);
    end
    n_vec++; if (to) begin n_bad++; $display("FAIL rst_wait_timeout: got no core_done want one"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if ({core_instr, core_length, core_start, busy, done, found} !== '0) begin n_bad++; $display("FAIL rst_mid_core: got %h want 0", {core_instr, core_length, core_start, busy, done, found}); end
    n_vec++; if ({found_instr, found_length, try_count} !== '0) begin n_bad++; $display("FAIL rst_mid_found: got %h want 0", {found_instr, found_length, try_count}); end
    n_vec++; if (dbl_start != 0) begin n_bad++; $display("FAIL core_start_double: got %0d want 0", dbl_start); end
  endtask

  task automatic test_clamp();
    int s, t; bit to;
    lat = 0;
    run_search('0, 0, 1000, t, to);
    n_vec++; if (to || {done, found} !== 2'b10) begin n_bad++; $display("FAIL clamp0_status: got %b want 10", {done, found}); end
    n_vec++; if (t != 26 || last_instr !== make_instr(26, 1, 25)) begin n_bad++; $display("FAIL clamp0_tries: got %0d %h want 26 %h", t, last_instr, make_instr(26, 1, 25)); end
    @(negedge clk);
    b_target = make_instr(2, 14, 0) ^ PAD; b_max_len = 4'd15; b_start = 1'b1; s = b_issue_total;
    @(negedge clk);
    b_start = 1'b0; to = 1'b1;
    for (int c = 0; c < 30000; c++) begin
      if (b_done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    t = b_issue_total - s;
    n_vec++; if (to || {b_busy, b_found} !== 2'b01) begin n_bad++; $display("FAIL clamp15_status: got %b want 01", {b_busy, b_found}); end
    n_vec++; if (b_found_length !== 4'd14 || b_core_length !== 4'd14) begin n_bad++; $display("FAIL clamp15_len: got %0d/%0d want 14", b_found_length, b_core_length); end
    n_vec++; if (t != tries_to_find(2, 13, 14, 0)) begin n_bad++; $display("FAIL clamp15_tries: got %0d want %0d", t, tries_to_find(2, 13, 14, 0)); end
    n_vec++; if (b_found_instr !== make_instr(2, 14, 0) || b_try_count !== tc_ref(t)) begin n_bad++; $display("FAIL clamp15_match: got %h/%0d want %h/%0d", b_found_instr, b_try_count, make_instr(2, 14, 0), tc_ref(t)); end
  endtask

  initial begin
    test_reset();
    test_find_c();
    test_find_ab_start_busy();
    test_exhaust();
    test_random();
    test_abort();
    test_rst_check();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ntlm_crack_ctrl.md
Name: ntlm_crack_ctrl

Overview:
- Sequencer for the NTLM hash datapath (16-byte password buffer, 4-bit length, 128-bit digest).
- Enumerates candidate passwords over a fixed character set, shortest first, and issues each one to the hash core through a start/done handshake.
- Compares every returned digest against a target digest.
- Reports the first match, or reports exhaustion.
- Sits between the top-level host/control interface and one hash core instance.

Parameters:
- BASE_CHAR, 8'h61, ASCII code of charset digit 0 ('a').
- CHARSET_SIZE, 26, number of consecutive ASCII codes enumerated (2..95).
- MIN_LEN, 1, first candidate length tried (1..14).
- MAX_LEN_HW, 14, hard upper bound on candidate length (≤15, ≤16 bytes of buffer).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE, FOUND or EXHAUSTED.
- abort  in  1  level; forces return to IDLE.
- target_hash  in  [0:127]  digest to search for; sampled on accepted start.
- max_len  in  [0:3]  search length limit; sampled on accepted start.
- core_instr  out  [0:127]  candidate bytes, char0 at [0:7], unused bytes zero.
- core_length  out  [0:3]  candidate length.
- core_start  out  1  one-cycle request to hash core.
- core_done  in  1  one-cycle pulse; core_hash valid that cycle.
- core_hash  in  [0:127]  digest from core.
- busy  out  1  high in ISSUE/WAIT/CHECK.
- done  out  1  high in FOUND or EXHAUSTED.
- found  out  1  high in FOUND only.
- found_instr  out  [0:127]  matching candidate, valid while found.
- found_length  out  [0:3]  matching length, valid while found.
- try_count  out  [0:31]  candidates completed (optional feature).

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0, including core_instr and core_length.
  - Digit registers 0.
- Effective limit lim = clamp(max_len, MIN_LEN, MAX_LEN_HW), computed on start.
- Candidate encoding:
  - Digit registers d[0..MAX_LEN_HW-1], each 0..CHARSET_SIZE-1.
  - Byte i = BASE_CHAR + d[i] for i < len, otherwise 8'h00.
  - d[0] is the least-significant digit and increments fastest.
- States and transitions:
  - IDLE: on start, latch target_hash and lim; len = MIN_LEN, digits = 0; go to ISSUE.
  - ISSUE: core_start = 1 for exactly one cycle; core_instr and core_length are driven from the registers; go to WAIT.
  - WAIT: hold core_instr and core_length stable; on core_done, register core_hash and go to CHECK. No timeout.
  - CHECK:
    - Full 128-bit equality against the latched target.
    - On match: load found_instr and found_length; go to FOUND.
    - On no match, increment with ripple carry. Carry out of d[len-1] means overflow of this length:
      - If len == lim: go to EXHAUSTED.
      - Otherwise: len = len + 1, all digits = 0, go to ISSUE.
    - If there is no overflow: go to ISSUE.
- Latency: exactly 3 controller cycles per candidate plus core latency (ISSUE, ≥1 WAIT, CHECK).
- FOUND and EXHAUSTED hold their outputs until start (which begins a new search) or abort (which goes to IDLE).
- abort:
  - Takes effect next cycle from any state.
  - Clears found, done and busy.
  - A core_done arriving later while in IDLE is ignored.
- start while busy is ignored.
- core_done outside WAIT is ignored.
- rst mid-search: next cycle is IDLE with all reset values.

Optional Feature:
- Macro NTLM_CTRL_TRY_COUNT_EN.
- When defined:
  - try_count is a 32-bit counter, cleared on accepted start.
  - Incremented once per CHECK.
  - Saturates at 32'hFFFFFFFF.
  - Holds its value in FOUND, EXHAUSTED and IDLE.
- When undefined: try_count is constant 0 and no counter logic is built.

Decomposition:
- Package ntlm_pkg holds:
  - The state enum (IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUSTED).
  - Localparam HASH_W = 128, BUF_W = 128, LEN_W = 4.
  - Byte-packing helper constants.
- Sub-module ntlm_cand_counter:
  - Holds the digit registers, ripple increment, carry-out per length, and byte packing into core_instr.
  - The FSM lives in ntlm_crack_ctrl.

Test Plan:
- Bench core model: hash = {instr ^ 128'hA5..A5} with a programmable 1–5 cycle latency.
1. target = model("c"), max_len = 2 -> FOUND, found_instr[0:7] = 8'h63, found_length = 1, try_count = 3.
2. target = model("ab"), max_len = 3 -> FOUND, found_instr[0:15] = 16'h6162, found_length = 2, try_count = 53 (26 + 27).
3. Unreachable target, max_len = 2 -> EXHAUSTED after exactly 702 tries; found = 0, done = 1; "zz" is the last core_instr issued.
4. Assert abort during WAIT on try 10, then start a new search -> IDLE next cycle, the stale core_done is ignored, and the new search restarts from "a" with try_count = 0.
5. Assert rst during CHECK, plus start pulses while busy -> all outputs 0 after reset; start pulses while busy cause no restart; core_start is never high on two consecutive cycles.
6. max_len = 0 and max_len = 15 -> clamped to 1 and 14: the first case is EXHAUSTED after 26 tries; the second case reaches length 14 without length overflow.
